// File: rtl/cus43_tile_pixel_shifter_if.sv
// ----------------------------------------------------------------------------
// cus43_tile_pixel_shifter_if
// Bundles the tile-fetch inputs and the per-dot outputs of the tile pixel
// shifter.
//   master : drives FLIP, S3H, GD, COL, FINE, nHSYNC, nHBLANK and
//            receives DOT, OPAQUE, UNDERRUN, OVERRUN (and GRID)
//   slave  : the shifter itself (directions reversed)
// Optional feature macro: CUS43_GRID_DEBUG_EN adds the GRID debug output.
// ----------------------------------------------------------------------------
interface cus43_tile_pixel_shifter_if #(
    parameter int COL_W = 7
);
    logic             FLIP;      // screen flip, reverses pixel order in a group
    logic             S3H;       // load strobe, one clk per 4-dot group
    logic [7:0]       GD;        // tile PROM byte, 4 pixels x 2 bits
    logic [COL_W-1:0] COL;       // colour attribute sampled with GD
    logic [2:0]       FINE;      // fine-scroll delay, latched at line start
    logic             nHSYNC;    // horizontal sync, active low
    logic             nHBLANK;   // horizontal blank, active low
    logic [COL_W+1:0] DOT;       // {colour, pixel}, registered
    logic             OPAQUE;    // non-zero pixel outside blank, registered
    logic             UNDERRUN;  // sticky: group boundary with empty hold
    logic             OVERRUN;   // sticky: hold overwritten before use
`ifdef CUS43_GRID_DEBUG_EN
    logic             GRID;      // tile-grid debug marker, registered
`endif

    modport master (
        output FLIP, S3H, GD, COL, FINE, nHSYNC, nHBLANK,
        input  DOT, OPAQUE, UNDERRUN, OVERRUN
`ifdef CUS43_GRID_DEBUG_EN
        , input GRID
`endif
    );

    modport slave (
        input  FLIP, S3H, GD, COL, FINE, nHSYNC, nHBLANK,
        output DOT, OPAQUE, UNDERRUN, OVERRUN
`ifdef CUS43_GRID_DEBUG_EN
        , output GRID
`endif
    );
endinterface

// File: rtl/cus43_tile_pixel_shifter.sv
// ----------------------------------------------------------------------------
// cus43_tile_pixel_shifter
// Reading end of the tilemap fetch path: captures the tile PROM byte and
// colour attribute on S3H, serializes them into 2-bit pixels (4 dots per
// group), applies the per-line fine-scroll delay and blanking, and presents
// a registered per-dot colour index to the priority mixer.
// Ports:
//   CLK_6M : dot clock, sole clock
//   rst    : synchronous, active-high reset
//   bus    : cus43_tile_pixel_shifter_if.slave (FLIP, S3H, GD, COL, FINE,
//            nHSYNC, nHBLANK in; DOT, OPAQUE, UNDERRUN, OVERRUN out)
// Parameters:
//   MAX_FINE : deepest fine-scroll delay in dots (1..7)
//   COL_W    : colour attribute width; DOT is COL_W+2 bits
// Optional feature macro: CUS43_GRID_DEBUG_EN adds GRID, which marks the
// first dot of every tile and forces that dot to all-ones / opaque.
// ----------------------------------------------------------------------------
module cus43_tile_pixel_shifter #(
    parameter int MAX_FINE = 3,
    parameter int COL_W    = 7
) (
    input  logic                          CLK_6M,
    input  logic                          rst,
    cus43_tile_pixel_shifter_if.slave     bus
);
    localparam logic [2:0] MAX_FINE_Q = 3'(MAX_FINE);

    typedef logic [COL_W+1:0] dot_t;

    logic             nhsync_q;
    logic             line_start;
    logic [1:0]       phase;
    logic             load;
    logic [2:0]       fine_q;
    logic [7:0]       hold_gd;
    logic [COL_W-1:0] hold_col;
    logic             hold_valid;
    logic [7:0]       sh_gd;
    logic [COL_W-1:0] sh_col;
    dot_t             dly [MAX_FINE];
    dot_t             ser;
    dot_t             tap;
    logic [1:0]       sel;
    logic             underrun;
    logic             overrun;
    dot_t             dot_q;
    logic             opaque_q;

    assign line_start = nhsync_q & ~bus.nHSYNC;
    // The shifter is reloaded on the edge that ends the last dot of a group.
    assign load       = (phase == 2'd3);

    // NOTE: every variable an always_comb writes gets a value at the top of
    // the block, so no path can leave it holding state (no latch).
    always_comb begin
        sel = bus.FLIP ? phase : ~phase;   // ~phase == 3-phase for 2 bits
        ser = {sh_col, sh_gd[{sel, 1'b0} +: 2]};
        tap = ser;                         // fine_q == 0 bypasses the line
        for (int i = 0; i < MAX_FINE; i++) begin
            if (fine_q == 3'(i + 1)) tap = dly[i];
        end
    end

    // Line timing: sync edge detect, dot phase, per-line fine scroll.
    // NOTE: state registers use non-blocking assignments so every always_ff
    // sees the pre-edge value of every other register.
    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            nhsync_q <= 1'b1;              // idle level of an active-low sync
            phase    <= 2'd0;
            fine_q   <= 3'd0;
        end else begin
            nhsync_q <= bus.nHSYNC;
            phase    <= line_start ? 2'd0 : phase + 2'd1;
            if (line_start)
                fine_q <= (bus.FINE > MAX_FINE_Q) ? MAX_FINE_Q : bus.FINE;
        end
    end

    // Hold stage, shifter and the sticky error flags.
    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            hold_gd    <= '0;
            hold_col   <= '0;
            hold_valid <= 1'b0;
            sh_gd      <= '0;
            sh_col     <= '0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // New data always wins the hold; a load on the same edge has
            // already taken the old contents, so hold_valid stays set.
            if (bus.S3H) begin
                hold_gd    <= bus.GD;
                hold_col   <= bus.COL;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            // An empty hold at a group boundary yields transparent pixels but
            // keeps the previous colour.
            if (load) begin
                if (hold_valid) begin
                    sh_gd  <= hold_gd;
                    sh_col <= hold_col;
                end else begin
                    sh_gd  <= '0;
                end
            end

            if (line_start) begin
                underrun <= 1'b0;
                overrun  <= 1'b0;
            end else begin
                if (load && !hold_valid)           underrun <= 1'b1;
                if (bus.S3H && hold_valid && !load) overrun <= 1'b1;
            end
        end
    end

    // Fine-scroll delay line; dly[i] is the serialized dot from i+1 clks ago.
    // NOTE: the delay line is only MAX_FINE words and is cleared on reset so
    // the first dots after reset are defined; larger storage would not be.
    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            for (int i = 0; i < MAX_FINE; i++) dly[i] <= '0;
        end else begin
            dly[0] <= ser;
            for (int i = 1; i < MAX_FINE; i++) dly[i] <= dly[i-1];
        end
    end

`ifdef CUS43_GRID_DEBUG_EN
    // Group parity from line start: even groups begin a new 8-dot tile.
    logic grp_odd;
    logic tile_first;
    logic grid_q;

    assign tile_first = bus.nHBLANK & (phase == 2'd0) & ~grp_odd;

    always_ff @(posedge CLK_6M) begin
        if (rst)             grp_odd <= 1'b0;
        else if (line_start) grp_odd <= 1'b0;
        else if (load)       grp_odd <= ~grp_odd;
    end
`endif

    // Output register: blanking masks the dot, the pipeline keeps running.
    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            dot_q    <= '0;
            opaque_q <= 1'b0;
`ifdef CUS43_GRID_DEBUG_EN
            grid_q   <= 1'b0;
`endif
        end else begin
            dot_q    <= bus.nHBLANK ? tap : '0;
            opaque_q <= bus.nHBLANK & (tap[1:0] != 2'b00);
`ifdef CUS43_GRID_DEBUG_EN
            grid_q   <= tile_first;
            if (tile_first) begin
                dot_q    <= '1;
                opaque_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.DOT      = dot_q;
    assign bus.OPAQUE   = opaque_q;
    assign bus.UNDERRUN = underrun;
    assign bus.OVERRUN  = overrun;
`ifdef CUS43_GRID_DEBUG_EN
    assign bus.GRID     = grid_q;
`endif

endmodule
